stage_mem: RTL and testbench

Memory-access stage of the five-stage RV32I pipeline, between the EX/MEM register and `pipe_mem_wb`. It executes loads and stores over the byte-wide memory port as a byte-sequenced state machine. It holds the pipeline through `stall_req_o` until the access completes, then presents the register-write triple that `pipe_mem_wb` captures. Non-memory instructions pass through combinationally with zero added latency.

---
 rtl/stage_mem.sv | 172 +++++++++++++++++
 tb/tb_stage_mem.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_mem.sv
// stage_mem: RV32I memory-access stage running loads/stores byte by byte over an 8-bit port.
// Optional macro MEM_FORWARD_EN adds the fwd_* outputs toward ID.
module stage_mem #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [5:0]            stall_i,
   input  logic                  write_i,
   input  logic [4:0]            regw_addr_i,
   input  logic [31:0]           regw_data_i,
   input  logic [3:0]            mem_op_i,
   input  logic [31:0]           mem_addr_i,
   input  logic [31:0]           mem_wdata_i,
   input  logic                  mem_ready_i,
   input  logic [7:0]            mem_rdata_i,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [7:0]            mem_wdata_o,
   output logic                  stall_req_o,
   output logic                  write_o,
   output logic [4:0]            regw_addr_o,
   output logic [31:0]           regw_data_o
`ifdef MEM_FORWARD_EN
   ,
   output logic                  fwd_write_o,
   output logic [4:0]            fwd_addr_o,
   output logic [31:0]           fwd_data_o
`endif
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_LHU = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [1:0]            r_k;
   logic [31:0]           r_buf;
   logic                  r_req;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_wdata;

   logic                  w_is_mem;
   logic                  w_is_store;
   logic [1:0]            w_last_k;
   logic [1:0]            w_k_inc;
   logic [ADDR_WIDTH-1:0] w_base;
   logic                  w_unused_stall;

   function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
      return word[8*idx +: 8];
   endfunction

   function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [31:0] buf_v);
      case (op)
         OP_LB:   return {{24{buf_v[7]}}, buf_v[7:0]};
         OP_LH:   return {{16{buf_v[15]}}, buf_v[15:0]};
         OP_LBU:  return {24'h0, buf_v[7:0]};
         OP_LHU:  return {16'h0, buf_v[15:0]};
         default: return buf_v;
      endcase
   endfunction

   assign w_is_mem       = (mem_op_i >= OP_LB) && (mem_op_i <= OP_SW);
   assign w_is_store     = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
   assign w_base         = mem_addr_i[ADDR_WIDTH-1:0];
   assign w_k_inc        = r_k + 2'd1;
   assign w_unused_stall = ^{stall_i[5], stall_i[3:0]};

   // Index of the final byte: 0 for byte ops, 1 for halfwords, 3 for words.
   always_comb begin
      w_last_k = 2'd0;
      case (mem_op_i)
         OP_LH, OP_LHU, OP_SH: w_last_k = 2'd1;
         OP_LW, OP_SW:         w_last_k = 2'd3;
         default:              w_last_k = 2'd0;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      stall_req_o  = 1'b0;
      write_o      = write_i;
      regw_addr_o  = regw_addr_i;
      regw_data_o  = regw_data_i;
      case (r_state)
         S_IDLE: begin
            if (w_is_mem) begin
               w_state_next = S_ACCESS;
               stall_req_o  = 1'b1;
               write_o      = 1'b0;
            end
         end
         S_ACCESS: begin
            stall_req_o = 1'b1;
            write_o     = 1'b0;
            if (mem_ready_i && (r_k == w_last_k)) w_state_next = S_DONE;
         end
         S_DONE: begin
            if (!w_is_store) regw_data_o = load_extend(mem_op_i, r_buf);
            if (!stall_i[4]) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
      if (reset) begin
         stall_req_o = 1'b0;
         write_o     = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_k     <= 2'd0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= 8'h0;
         r_buf   <= 32'h0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            S_IDLE: begin
               if (w_is_mem) begin
                  r_k     <= 2'd0;
                  r_req   <= 1'b1;
                  r_we    <= w_is_store;
                  r_addr  <= w_base;
                  r_wdata <= byte_of(mem_wdata_i, 2'd0);
                  r_buf   <= 32'h0;
               end
            end
            S_ACCESS: begin
               if (mem_ready_i) begin
                  if (!w_is_store) r_buf[8*r_k +: 8] <= mem_rdata_i;
                  if (r_k != w_last_k) begin
                     r_k     <= w_k_inc;
                     r_addr  <= w_base + ADDR_WIDTH'(w_k_inc);
                     r_wdata <= byte_of(mem_wdata_i, w_k_inc);
                  end else begin
                     r_req <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_req_o   = r_req;
   assign mem_we_o    = r_we;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;

`ifdef MEM_FORWARD_EN
   // Load data is not forwardable until the access has finished.
   assign fwd_write_o = write_o & ~stall_req_o;
   assign fwd_addr_o  = regw_addr_o;
   assign fwd_data_o  = regw_data_o;
`endif

endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: directed vector table plus hand sequences for stage_mem, with a byte memory responder.
module tb_stage_mem;

   logic        clock;
   logic        reset;
   logic [5:0]  stall_i;
   logic        write_i;
   logic [4:0]  regw_addr_i;
   logic [31:0] regw_data_i;
   logic [3:0]  mem_op_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic        mem_ready_i;
   logic [7:0]  mem_rdata_i;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [7:0]  mem_wdata_o;
   logic        stall_req_o;
   logic        write_o;
   logic [4:0]  regw_addr_o;
   logic [31:0] regw_data_o;
`ifdef MEM_FORWARD_EN
   logic        fwd_write_o;
   logic [4:0]  fwd_addr_o;
   logic [31:0] fwd_data_o;
`endif

   stage_mem #(.ADDR_WIDTH(32)) dut (
      .clock       (clock),
      .reset       (reset),
      .stall_i     (stall_i),
      .write_i     (write_i),
      .regw_addr_i (regw_addr_i),
      .regw_data_i (regw_data_i),
      .mem_op_i    (mem_op_i),
      .mem_addr_i  (mem_addr_i),
      .mem_wdata_i (mem_wdata_i),
      .mem_ready_i (mem_ready_i),
      .mem_rdata_i (mem_rdata_i),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .stall_req_o (stall_req_o),
      .write_o     (write_o),
      .regw_addr_o (regw_addr_o),
      .regw_data_o (regw_data_o)
`ifdef MEM_FORWARD_EN
      ,
      .fwd_write_o (fwd_write_o),
      .fwd_addr_o  (fwd_addr_o),
      .fwd_data_o  (fwd_data_o)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Byte memory responder: ready after wait_cfg wait cycles per byte.
   logic [7:0]  mem [0:1023];
   int          wait_cfg;
   int          wcnt;
   int          req_cycles;
   int          viol;
   logic [31:0] xfer_q [$];

   assign mem_ready_i = mem_req_o && (wcnt >= wait_cfg);
   assign mem_rdata_i = mem[mem_addr_o[9:0]];

   initial begin
      wcnt       = 0;
      req_cycles = 0;
      viol       = 0;
   end

   always @(posedge clock) begin
      if (mem_req_o && !mem_ready_i) wcnt <= wcnt + 1;
      else                           wcnt <= 0;
      if (mem_req_o) req_cycles <= req_cycles + 1;
      if (mem_req_o && mem_ready_i) begin
         xfer_q.push_back(mem_addr_o);
         if (mem_we_o) mem[mem_addr_o[9:0]] <= mem_wdata_o;
      end
   end

   always @(negedge clock) begin
      if (!reset && mem_req_o && !stall_req_o) viol <= viol + 1;
   end

   int total;
   int bad;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        wr;
      logic [4:0]  rd;
      logic [31:0] alu;
      int          waits;
      logic [31:0] exp_data;
      int          exp_stall;
      int          exp_n;
   } vec_t;

   vec_t vecs[12];

   task automatic set_inputs(input vec_t v);
      mem_op_i    = v.op;
      mem_addr_i  = v.addr;
      mem_wdata_i = v.wdata;
      write_i     = v.wr;
      regw_addr_i = v.rd;
      regw_data_i = v.alu;
      wait_cfg    = v.waits;
   endtask

   // Called at posedge+1; returns at posedge+1 after the instruction has left the stage.
   task automatic run_vec(input vec_t v, input string nm);
      int cyc;
      int q0;
      int r0;
      bit done;
      stall_i = 6'h00;
      set_inputs(v);
      q0   = xfer_q.size();
      r0   = req_cycles;
      cyc  = 0;
      done = 1'b0;
      for (int t = 0; t < 60; t++) begin
         #1;
         if (!stall_req_o) begin
            done = 1'b1;
            break;
         end
         cyc++;
`ifdef MEM_FORWARD_EN
         if (cyc == 2) chk({nm, " fwd_busy"}, {31'h0, fwd_write_o}, 32'h0);
`endif
         @(posedge clock);
         #1;
      end
      chk({nm, " finished"}, {31'h0, done}, 32'h1);
      chk({nm, " stall"}, cyc, v.exp_stall);
      chk({nm, " write"}, {31'h0, write_o}, {31'h0, v.wr});
      chk({nm, " rd"}, {27'h0, regw_addr_o}, {27'h0, v.rd});
      chk({nm, " data"}, regw_data_o, v.exp_data);
      chk({nm, " xfers"}, xfer_q.size() - q0, v.exp_n);
      chk({nm, " req_cyc"}, req_cycles - r0, (v.exp_stall == 0) ? 0 : v.exp_stall - 1);
`ifdef MEM_FORWARD_EN
      chk({nm, " fwd_write"}, {31'h0, fwd_write_o}, {31'h0, v.wr});
      chk({nm, " fwd_data"}, fwd_data_o, v.exp_data);
`endif
      @(posedge clock);
      #1;
      mem_op_i = 4'd0;
      write_i  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int q0;
      logic [31:0] hold_data;
      total = 0;
      bad   = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[10'h100] = 8'h78; mem[10'h101] = 8'h56; mem[10'h102] = 8'h34; mem[10'h103] = 8'h12;
      mem[10'h104] = 8'h9A; mem[10'h105] = 8'hBC;
      mem[10'h010] = 8'h80;
      mem[10'h020] = 8'h00; mem[10'h021] = 8'h80;

      //            op     addr        wdata         wr    rd     alu          w  exp           st n
      vecs[0]  = '{4'd0, 32'h0,      32'h0,        1'b1, 5'd5, 32'h1234,    0, 32'h00001234, 0, 0};
      vecs[1]  = '{4'd3, 32'h100,    32'h0,        1'b1, 5'd6, 32'h100,     0, 32'h12345678, 5, 4};
      vecs[2]  = '{4'd1, 32'h10,     32'h0,        1'b1, 5'd7, 32'h10,      0, 32'hFFFFFF80, 2, 1};
      vecs[3]  = '{4'd4, 32'h10,     32'h0,        1'b1, 5'd8, 32'h10,      0, 32'h00000080, 2, 1};
      vecs[4]  = '{4'd2, 32'h20,     32'h0,        1'b1, 5'd9, 32'h20,      0, 32'hFFFF8000, 3, 2};
      vecs[5]  = '{4'd5, 32'h20,     32'h0,        1'b1, 5'd10, 32'h20,     0, 32'h00008000, 3, 2};
      vecs[6]  = '{4'd3, 32'h102,    32'h0,        1'b1, 5'd11, 32'h102,    0, 32'hBC9A1234, 5, 4};
      vecs[7]  = '{4'd7, 32'h1FF,    32'hAABBCCDD, 1'b0, 5'd0, 32'h1FF,     2, 32'h000001FF, 7, 2};
      vecs[8]  = '{4'd8, 32'h300,    32'hDEADBEEF, 1'b0, 5'd0, 32'h300,     1, 32'h00000300, 9, 4};
      vecs[9]  = '{4'd3, 32'h300,    32'h0,        1'b1, 5'd12, 32'h300,    0, 32'hDEADBEEF, 5, 4};
      vecs[10] = '{4'd9, 32'h40,     32'h0,        1'b1, 5'd0, 32'hCAFE,    0, 32'h0000CAFE, 0, 0};
      vecs[11] = '{4'd1, 32'h103,    32'h0,        1'b1, 5'd13, 32'h103,    1, 32'h00000012, 3, 1};

      reset       = 1'b1;
      stall_i     = 6'h00;
      wait_cfg    = 0;
      write_i     = 1'b1;
      regw_addr_i = 5'd3;
      regw_data_i = 32'h55;
      mem_op_i    = 4'd3;
      mem_addr_i  = 32'h100;
      mem_wdata_i = 32'h0;
      @(posedge clock); #1;
      @(posedge clock); #1;
      chk("rst stall", {31'h0, stall_req_o}, 32'h0);
      chk("rst write", {31'h0, write_o}, 32'h0);
      chk("rst req", {31'h0, mem_req_o}, 32'h0);
      chk("rst addr", mem_addr_o, 32'h0);
      reset    = 1'b0;
      mem_op_i = 4'd0;

      for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      chk("sh byte0", {24'h0, mem[10'h1FF]}, 32'hDD);
      chk("sh byte1", {24'h0, mem[10'h200]}, 32'hCC);
      chk("sh untouched", {24'h0, mem[10'h201]}, 32'h00);

      // DONE held by stall_i[4]: result stable, no new request.
      stall_i = 6'h10;
      set_inputs(vecs[1]);
      q0 = xfer_q.size();
      for (int t = 0; t < 20; t++) begin
         #1;
         if (!stall_req_o) break;
         @(posedge clock); #1;
      end
      hold_data = regw_data_o;
      chk("hold data", hold_data, 32'h12345678);
      for (int c = 0; c < 3; c++) begin
         @(posedge clock); #2;
         chk($sformatf("hold%0d data", c), regw_data_o, 32'h12345678);
         chk($sformatf("hold%0d req", c), {31'h0, mem_req_o}, 32'h0);
         chk($sformatf("hold%0d stall", c), {31'h0, stall_req_o}, 32'h0);
`ifdef MEM_FORWARD_EN
         chk($sformatf("hold%0d fwd", c), {31'h0, fwd_write_o}, 32'h1);
`endif
      end
      chk("hold xfers", xfer_q.size() - q0, 4);
      for (int b = 0; b < 4; b++) begin
         if (xfer_q.size() > q0 + b) chk($sformatf("lw addr%0d", b), xfer_q[q0 + b], 32'h100 + b);
      end
      stall_i = 6'h00;
      @(posedge clock); #1;
      mem_op_i = 4'd0;
      #1;
      chk("release idle", {31'h0, stall_req_o}, 32'h0);

      // Reset during byte 2 of a word load.
      @(posedge clock); #1;
      set_inputs(vecs[1]);
      @(posedge clock); #1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      chk("mid byte2 addr", mem_addr_o, 32'h102);
      reset = 1'b1;
      #1;
      chk("mid rst stall", {31'h0, stall_req_o}, 32'h0);
      chk("mid rst write", {31'h0, write_o}, 32'h0);
      @(posedge clock); #1;
      chk("mid rst req", {31'h0, mem_req_o}, 32'h0);
      chk("mid rst we", {31'h0, mem_we_o}, 32'h0);
      chk("mid rst addr", mem_addr_o, 32'h0);
      reset    = 1'b0;
      mem_op_i = 4'd0;
      #1;
      chk("mid after stall", {31'h0, stall_req_o}, 32'h0);
      @(posedge clock); #1;
      run_vec(vecs[2], "post_rst_lb");

      chk("req outside access", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
